scan_mux: RTL and testbench

- Parametrised, registered N-channel, W-bit multiplexer. It generalises the team's fixed 8:1 single-bit mux.
- Two modes:
  - manual: select is loaded externally.
  - scan: the select auto-advances through all channels, holding each for a programmable dwell time.
- Sits between parallel data sources and a single serial consumer, e.g. a display/LED scanner or a channel-sampling front end.

---
 rtl/scan_mux_pkg.sv | 60 ++++++
 rtl/scan_mux_dwell_ctr.sv | 40 ++++
 rtl/scan_mux.sv | 156 +++++++++++++++
 tb/tb_scan_mux.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_mux_pkg.sv
// ----------------------------------------------------------------------------
// scan_mux_pkg
// Shared definitions for the scan_mux block:
//   - mode input encoding (MODE_MANUAL / MODE_SCAN)
//   - controller state type (MANUAL / SCAN)
//   - next_sel(): cyclic search for the next enabled channel after the current
//     one, reporting whether the search passed through index 0 (wrap) and
//     whether any enabled channel was found at all.
// Channel counts above MAX_CHANNELS are not supported by next_sel().
// ----------------------------------------------------------------------------
package scan_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int unsigned MAX_CHANNELS = 64;
    localparam int unsigned MAX_SEL_W    = 6;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] sel;
        logic        wrap;
        logic        found;
    } next_sel_t;

    // Steps 1..channels past cur; the first enabled index wins. Stepping a full
    // lap lands back on cur, so a lone enabled channel re-selects itself.
    function automatic next_sel_t next_sel(
        input logic [31:0]             cur,
        input logic [MAX_CHANNELS-1:0] mask,
        input logic [31:0]             channels
    );
        next_sel_t   res;
        logic [31:0] idx;
        logic        crossed;
        res.sel   = cur;
        res.wrap  = 1'b0;
        res.found = 1'b0;
        for (int unsigned s = 1; s <= MAX_CHANNELS; s++) begin
            if ((s <= channels) && !res.found) begin
                idx     = cur + s;
                crossed = (idx >= channels);
                if (crossed) begin
                    idx = idx - channels;
                end
                if (mask[idx[MAX_SEL_W-1:0]]) begin
                    res.sel   = idx;
                    res.wrap  = crossed;
                    res.found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/scan_mux_dwell_ctr.sv
// ----------------------------------------------------------------------------
// scan_mux_dwell_ctr
// Dwell timer for scan mode. Counts 0..DWELL-1 while enabled and flags the
// terminal count combinationally so the owner can act on the same edge that
// returns the counter to 0.
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   i_clear  restart the count at 0 (wins over i_en)
//   i_en     count enable
//   o_tc     high while enabled and sitting on the last dwell cycle
// ----------------------------------------------------------------------------
module scan_mux_dwell_ctr
    import scan_mux_pkg::*;
#(
    parameter int unsigned DWELL = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned      CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc = i_en && (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/scan_mux.sv
// ----------------------------------------------------------------------------
// scan_mux
// Registered CHANNELS-way, WIDTH-bit multiplexer with manual and auto-scan
// channel selection.
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_ch_mask   per-channel enable (only with SCAN_MUX_CHAN_MASK_EN defined)
//   i_d         packed channel data, channel k at i_d[k*WIDTH +: WIDTH]
//   i_mode      0 = manual, 1 = scan
//   i_sel_in    channel number to load
//   i_sel_load  load strobe for i_sel_in (both modes)
//   o_y         registered data of the selected channel (lags o_cur_sel by 1)
//   o_y_valid   o_y reflects a legal, settled selection
//   o_cur_sel   channel currently selected
//   o_wrap      one-cycle pulse when a scan advance passes through channel 0
// Build option:
//   SCAN_MUX_CHAN_MASK_EN  adds i_ch_mask; scan skips disabled channels and
//                          loads of disabled channels are rejected. Without it
//                          every channel is enabled.
// ----------------------------------------------------------------------------
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned DWELL    = 20,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
`ifdef SCAN_MUX_CHAN_MASK_EN
    input  logic [CHANNELS-1:0]       i_ch_mask,
`endif
    input  logic [CHANNELS*WIDTH-1:0] i_d,
    input  logic                      i_mode,
    input  logic [SEL_W-1:0]          i_sel_in,
    input  logic                      i_sel_load,
    output logic [WIDTH-1:0]          o_y,
    output logic                      o_y_valid,
    output logic [SEL_W-1:0]          o_cur_sel,
    output logic                      o_wrap
);

    state_e           r_state;
    logic [SEL_W-1:0] r_cur_sel;
    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;
    logic             r_wrap;
    logic             r_primed;    // set after the first post-reset edge

    state_e              w_state_next;
    logic [CHANNELS-1:0] w_mask;
    logic                w_mask_any;
    logic                w_load_legal;
    logic                w_load_ok;
    logic                w_load_err;
    logic                w_ctr_clear;
    logic                w_ctr_en;
    logic                w_tc;
    logic                w_advance;
    next_sel_t           w_ns;
    logic [SEL_W-1:0]    w_adv_sel;
    logic [WIDTH-1:0]    w_y_next;

`ifdef SCAN_MUX_CHAN_MASK_EN
    assign w_mask = i_ch_mask;
`else
    assign w_mask = '1;
`endif

    assign w_mask_any = |w_mask;

    // Mode is a level: the state simply follows it one edge later.
    assign w_state_next = (i_mode == MODE_SCAN) ? SCAN : MANUAL;

    // A load is legal only for an existing, enabled channel. Values at or above
    // CHANNELS never match the loop and so stay illegal.
    always_comb begin
        w_load_legal = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (i_sel_in == SEL_W'(k)) begin
                w_load_legal = w_mask[k];
            end
        end
    end

    assign w_load_ok  = i_sel_load && w_load_legal;
    assign w_load_err = i_sel_load && !w_load_legal;

    // Entering or leaving scan, and any accepted load, restart the dwell.
    assign w_ctr_clear = (r_state != w_state_next) || w_load_ok;
    assign w_ctr_en    = (r_state == SCAN) && (i_mode == MODE_SCAN);

    scan_mux_dwell_ctr #(
        .DWELL (DWELL)
    ) u_dwell_ctr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_ctr_clear),
        .i_en    (w_ctr_en),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_ns      = next_sel(32'(r_cur_sel), MAX_CHANNELS'(w_mask), 32'(CHANNELS));
        w_adv_sel = r_cur_sel;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_ns.sel == 32'(k)) begin
                w_adv_sel = SEL_W'(k);
            end
        end
    end

    // A coincident load takes priority; an empty mask leaves nothing to go to.
    assign w_advance = w_tc && w_ns.found && !w_load_ok;

    always_comb begin
        w_y_next = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (r_cur_sel == SEL_W'(k)) begin
                w_y_next = i_d[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= MANUAL;
            r_cur_sel <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_wrap    <= 1'b0;
            r_primed  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_primed <= 1'b1;
            r_y      <= w_y_next;
            // Needs one edge of y sampling first; a rejected load or an empty
            // mask knocks it low for as long as the condition lasts.
            r_y_valid <= r_primed && w_mask_any && !w_load_err;
            r_wrap    <= w_advance && w_ns.wrap;
            if (w_load_ok) begin
                r_cur_sel <= i_sel_in;
            end else if (w_advance) begin
                r_cur_sel <= w_adv_sel;
            end
        end
    end

    assign o_y       = r_y;
    assign o_y_valid = r_y_valid;
    assign o_cur_sel = r_cur_sel;
    assign o_wrap    = r_wrap;

endmodule

// File: tb/tb_scan_mux.sv
// ----------------------------------------------------------------------------
// tb_scan_mux
// Directed bench for scan_mux. Instance A: WIDTH=1, CHANNELS=8, DWELL=20.
// Instance B: WIDTH=4, CHANNELS=5, DWELL=3 (non-power-of-two channel count).
// The channel-mask scenario is built only with SCAN_MUX_CHAN_MASK_EN.
// ----------------------------------------------------------------------------
module tb_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic        a_rst;
    logic [7:0]  a_d;
    logic        a_mode;
    logic [2:0]  a_sel_in;
    logic        a_sel_load;
    logic [0:0]  a_y;
    logic        a_y_valid;
    logic [2:0]  a_cur_sel;
    logic        a_wrap;
    // Instance B
    logic        b_rst;
    logic [19:0] b_d;
    logic        b_mode;
    logic [2:0]  b_sel_in;
    logic        b_sel_load;
    logic [3:0]  b_y;
    logic        b_y_valid;
    logic [2:0]  b_cur_sel;
    logic        b_wrap;
`ifdef SCAN_MUX_CHAN_MASK_EN
    logic [7:0]  a_mask = 8'hFF;
    logic [4:0]  b_mask = 5'h1F;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    scan_mux #(.WIDTH(1), .CHANNELS(8), .DWELL(20)) u_dut_a (
        .i_clk      (clk),
        .i_rst      (a_rst),
`ifdef SCAN_MUX_CHAN_MASK_EN
        .i_ch_mask  (a_mask),
`endif
        .i_d        (a_d),
        .i_mode     (a_mode),
        .i_sel_in   (a_sel_in),
        .i_sel_load (a_sel_load),
        .o_y        (a_y),
        .o_y_valid  (a_y_valid),
        .o_cur_sel  (a_cur_sel),
        .o_wrap     (a_wrap)
    );

    scan_mux #(.WIDTH(4), .CHANNELS(5), .DWELL(3)) u_dut_b (
        .i_clk      (clk),
        .i_rst      (b_rst),
`ifdef SCAN_MUX_CHAN_MASK_EN
        .i_ch_mask  (b_mask),
`endif
        .i_d        (b_d),
        .i_mode     (b_mode),
        .i_sel_in   (b_sel_in),
        .i_sel_load (b_sel_load),
        .o_y        (b_y),
        .o_y_valid  (b_y_valid),
        .o_cur_sel  (b_cur_sel),
        .o_wrap     (b_wrap)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        a_d = 8'b10101010;
        b_d = {4'hD, 4'hC, 4'hB, 4'hA, 4'h9};
        a_rst = 1'b1; a_mode = 1'b0; a_sel_in = 3'd0; a_sel_load = 1'b0;
        b_rst = 1'b1; b_mode = 1'b0; b_sel_in = 3'd0; b_sel_load = 1'b0;
        tick; tick;
        n_checks++; if (a_y !== 1'b0) begin n_fail++; $display("FAIL reset_y: got %0h want 0", a_y); end
        n_checks++; if (a_y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", a_y_valid); end
        n_checks++; if (a_cur_sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", a_cur_sel); end
        n_checks++; if (a_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %0b want 0", a_wrap); end
        n_checks++; if (b_y !== 4'h0) begin n_fail++; $display("FAIL reset_b_y: got %0h want 0", b_y); end
        a_rst = 1'b0; b_rst = 1'b0;
        tick;
        n_checks++; if (a_y_valid !== 1'b0) begin n_fail++; $display("FAIL valid_edge1: got %0b want 0", a_y_valid); end
        n_checks++; if (b_y !== 4'h9) begin n_fail++; $display("FAIL b_y_edge1: got %0h want 9", b_y); end
        tick;
        n_checks++; if (a_y_valid !== 1'b1) begin n_fail++; $display("FAIL valid_edge2: got %0b want 1", a_y_valid); end
        n_checks++; if (b_y_valid !== 1'b1) begin n_fail++; $display("FAIL b_valid_edge2: got %0b want 1", b_y_valid); end
    endtask

    task automatic test_manual;
        logic exp_y;
        for (int s = 0; s < 8; s++) begin
            a_sel_in = 3'(s); a_sel_load = 1'b1;
            tick;
            a_sel_load = 1'b0;
            n_checks++; if (a_cur_sel !== 3'(s)) begin n_fail++; $display("FAIL manual_sel: got %0d want %0d", a_cur_sel, s); end
            n_checks++; if (a_y_valid !== 1'b1) begin n_fail++; $display("FAIL manual_valid ch%0d: got %0b want 1", s, a_y_valid); end
            tick;
            exp_y = (s % 2 == 1);   // d = 10101010: odd channels are 1
            n_checks++; if (a_y !== exp_y) begin n_fail++; $display("FAIL manual_y ch%0d: got %0b want %0b", s, a_y, exp_y); end
            repeat (18) tick;
        end
    endtask

    task automatic test_scan;
        int   exp_sel;
        logic exp_wrap;
        logic exp_y;
        a_sel_in = 3'd0; a_sel_load = 1'b1; a_mode = 1'b1;  // mode change plus load
        tick;
        a_sel_load = 1'b0;
        n_checks++; if (a_cur_sel !== 3'd0) begin n_fail++; $display("FAIL scan_start_sel: got %0d want 0", a_cur_sel); end
        for (int t = 1; t <= 170; t++) begin
            tick;
            exp_sel  = (t / 20) % 8;
            exp_wrap = (t % 20 == 0) && (exp_sel == 0);
            exp_y    = (((t - 1) / 20) % 2 == 1);
            n_checks++; if (a_cur_sel !== 3'(exp_sel)) begin n_fail++; $display("FAIL scan_sel t=%0d: got %0d want %0d", t, a_cur_sel, exp_sel); end
            n_checks++; if (a_wrap !== exp_wrap) begin n_fail++; $display("FAIL scan_wrap t=%0d: got %0b want %0b", t, a_wrap, exp_wrap); end
            n_checks++; if (a_y !== exp_y) begin n_fail++; $display("FAIL scan_y t=%0d: got %0b want %0b", t, a_y, exp_y); end
        end
    endtask

    task automatic test_rst_mid_dwell;
        repeat (25) tick;   // 195 cycles into the scan: channel 1, mid-dwell
        n_checks++; if (a_cur_sel !== 3'd1) begin n_fail++; $display("FAIL middwell_pre: got %0d want 1", a_cur_sel); end
        a_rst = 1'b1;
        tick;
        n_checks++; if (a_cur_sel !== 3'd0) begin n_fail++; $display("FAIL middwell_sel: got %0d want 0", a_cur_sel); end
        n_checks++; if (a_y_valid !== 1'b0) begin n_fail++; $display("FAIL middwell_valid: got %0b want 0", a_y_valid); end
        n_checks++; if (a_y !== 1'b0) begin n_fail++; $display("FAIL middwell_y: got %0b want 0", a_y); end
        a_rst = 1'b0;
        tick;               // mode still 1: scan restarts with a fresh dwell
        repeat (19) tick;
        n_checks++; if (a_cur_sel !== 3'd0) begin n_fail++; $display("FAIL middwell_hold: got %0d want 0", a_cur_sel); end
        n_checks++; if (a_y_valid !== 1'b1) begin n_fail++; $display("FAIL middwell_revalid: got %0b want 1", a_y_valid); end
        tick;
        n_checks++; if (a_cur_sel !== 3'd1) begin n_fail++; $display("FAIL middwell_adv: got %0d want 1", a_cur_sel); end
    endtask

    task automatic test_load_vs_tc;
        a_sel_in = 3'd7; a_sel_load = 1'b1;
        tick;
        a_sel_load = 1'b0;
        repeat (19) tick;
        n_checks++; if (a_cur_sel !== 3'd7) begin n_fail++; $display("FAIL ltc_pre: got %0d want 7", a_cur_sel); end
        a_sel_in = 3'd3; a_sel_load = 1'b1;   // same edge as the 7->0 advance
        tick;
        a_sel_load = 1'b0;
        n_checks++; if (a_cur_sel !== 3'd3) begin n_fail++; $display("FAIL ltc_sel: got %0d want 3", a_cur_sel); end
        n_checks++; if (a_wrap !== 1'b0) begin n_fail++; $display("FAIL ltc_wrap: got %0b want 0", a_wrap); end
        repeat (19) tick;
        n_checks++; if (a_cur_sel !== 3'd3) begin n_fail++; $display("FAIL ltc_restart: got %0d want 3", a_cur_sel); end
        tick;
        n_checks++; if (a_cur_sel !== 3'd4) begin n_fail++; $display("FAIL ltc_adv: got %0d want 4", a_cur_sel); end
    endtask

    task automatic test_freeze;
        a_mode = 1'b0;
        tick;
        repeat (40) tick;
        n_checks++; if (a_cur_sel !== 3'd4) begin n_fail++; $display("FAIL freeze_sel: got %0d want 4", a_cur_sel); end
        n_checks++; if (a_wrap !== 1'b0) begin n_fail++; $display("FAIL freeze_wrap: got %0b want 0", a_wrap); end
    endtask

    task automatic test_non_pow2;
        int         exp_sel;
        logic       exp_wrap;
        logic [3:0] exp_y;
        b_mode = 1'b1;
        tick;
        for (int t = 1; t <= 32; t++) begin
            tick;
            exp_sel  = (t / 3) % 5;
            exp_wrap = (t % 3 == 0) && (exp_sel == 0);
            exp_y    = 4'(9 + ((t - 1) / 3) % 5);
            n_checks++; if (b_cur_sel !== 3'(exp_sel)) begin n_fail++; $display("FAIL np2_sel t=%0d: got %0d want %0d", t, b_cur_sel, exp_sel); end
            n_checks++; if (b_wrap !== exp_wrap) begin n_fail++; $display("FAIL np2_wrap t=%0d: got %0b want %0b", t, b_wrap, exp_wrap); end
            n_checks++; if (b_y !== exp_y) begin n_fail++; $display("FAIL np2_y t=%0d: got %0h want %0h", t, b_y, exp_y); end
        end
    endtask

    task automatic test_illegal_load;
        b_mode = 1'b0;
        b_sel_in = 3'd2; b_sel_load = 1'b1;
        tick;
        n_checks++; if (b_cur_sel !== 3'd2) begin n_fail++; $display("FAIL ill_pre: got %0d want 2", b_cur_sel); end
        b_sel_in = 3'd6;
        tick;
        n_checks++; if (b_cur_sel !== 3'd2) begin n_fail++; $display("FAIL ill6_sel: got %0d want 2", b_cur_sel); end
        n_checks++; if (b_y_valid !== 1'b0) begin n_fail++; $display("FAIL ill6_valid: got %0b want 0", b_y_valid); end
        b_sel_load = 1'b0;
        tick;
        n_checks++; if (b_y_valid !== 1'b1) begin n_fail++; $display("FAIL ill6_recover: got %0b want 1", b_y_valid); end
        n_checks++; if (b_y !== 4'hB) begin n_fail++; $display("FAIL ill6_y: got %0h want b", b_y); end
        b_sel_in = 3'd5; b_sel_load = 1'b1;
        tick;
        b_sel_load = 1'b0;
        n_checks++; if (b_cur_sel !== 3'd2) begin n_fail++; $display("FAIL ill5_sel: got %0d want 2", b_cur_sel); end
        n_checks++; if (b_y_valid !== 1'b0) begin n_fail++; $display("FAIL ill5_valid: got %0b want 0", b_y_valid); end
        b_sel_in = 3'd4; b_sel_load = 1'b1;
        tick;
        b_sel_load = 1'b0;
        n_checks++; if (b_cur_sel !== 3'd4) begin n_fail++; $display("FAIL legal4_sel: got %0d want 4", b_cur_sel); end
        n_checks++; if (b_y_valid !== 1'b1) begin n_fail++; $display("FAIL legal4_valid: got %0b want 1", b_y_valid); end
        tick;
        n_checks++; if (b_y !== 4'hD) begin n_fail++; $display("FAIL legal4_y: got %0h want d", b_y); end
    endtask

`ifdef SCAN_MUX_CHAN_MASK_EN
    task automatic test_mask;
        int   idx;
        int   exp_sel;
        logic exp_wrap;
        a_mask = 8'b00100101;
        a_sel_in = 3'd0; a_sel_load = 1'b1; a_mode = 1'b1;
        tick;
        a_sel_load = 1'b0;
        for (int t = 1; t <= 150; t++) begin
            tick;
            idx      = (t / 20) % 3;
            exp_sel  = (idx == 0) ? 0 : ((idx == 1) ? 2 : 5);
            exp_wrap = (t % 20 == 0) && (idx == 0);
            n_checks++; if (a_cur_sel !== 3'(exp_sel)) begin n_fail++; $display("FAIL mask_sel t=%0d: got %0d want %0d", t, a_cur_sel, exp_sel); end
            n_checks++; if (a_wrap !== exp_wrap) begin n_fail++; $display("FAIL mask_wrap t=%0d: got %0b want %0b", t, a_wrap, exp_wrap); end
        end
        a_mask = 8'h00;
        tick;
        n_checks++; if (a_y_valid !== 1'b0) begin n_fail++; $display("FAIL mask0_valid: got %0b want 0", a_y_valid); end
        repeat (40) tick;
        n_checks++; if (a_cur_sel !== 3'd2) begin n_fail++; $display("FAIL mask0_sel: got %0d want 2", a_cur_sel); end
        n_checks++; if (a_y_valid !== 1'b0) begin n_fail++; $display("FAIL mask0_valid_hold: got %0b want 0", a_y_valid); end
        a_mask = 8'b00100101; a_mode = 1'b0;
        tick;
        n_checks++; if (a_y_valid !== 1'b1) begin n_fail++; $display("FAIL mask_back_valid: got %0b want 1", a_y_valid); end
        a_sel_in = 3'd1; a_sel_load = 1'b1;
        tick;
        n_checks++; if (a_cur_sel !== 3'd2) begin n_fail++; $display("FAIL masked_load_sel: got %0d want 2", a_cur_sel); end
        n_checks++; if (a_y_valid !== 1'b0) begin n_fail++; $display("FAIL masked_load_valid: got %0b want 0", a_y_valid); end
        a_sel_in = 3'd5;
        tick;
        a_sel_load = 1'b0;
        n_checks++; if (a_cur_sel !== 3'd5) begin n_fail++; $display("FAIL enabled_load_sel: got %0d want 5", a_cur_sel); end
        n_checks++; if (a_y_valid !== 1'b1) begin n_fail++; $display("FAIL enabled_load_valid: got %0b want 1", a_y_valid); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_manual;
        test_scan;
        test_rst_mid_dwell;
        test_load_vs_tc;
        test_freeze;
        test_non_pow2;
        test_illegal_load;
`ifdef SCAN_MUX_CHAN_MASK_EN
        test_mask;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
